// File: rtl/pipe_scheduler_if.sv
// Bundle carrying the game-control inputs and column/score outputs of the pipe scheduler.
interface pipe_scheduler_if;
    logic        start;
    logic        tick;
    logic        gameover;
    logic [15:0] pipeRight;
    logic        colValid;
    logic [7:0]  score;
    logic        busy;

    modport master (
        output start, tick, gameover,
        input  pipeRight, colValid, score, busy
    );

    modport slave (
        input  start, tick, gameover,
        output pipeRight, colValid, score, busy
    );
endinterface

// File: rtl/pipe_scheduler.sv
// Generates the scrolling pipe columns for the 16-row playfield: blank spacing
// columns, then solid pipe columns with an LFSR-placed flight gap; keeps score.
module pipe_scheduler #(
    parameter int         PIPE_WIDTH   = 2,
    parameter int         PIPE_SPACING = 6,
    parameter int         GAP_SIZE     = 4,
    parameter int         MIN_GAP_TOP  = 1,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic            clkM,
    input  logic            reset,
    pipe_scheduler_if.slave bus
);
    // Number of legal gap positions that keep the gap MIN_GAP_TOP rows off both edges.
    localparam int GAP_RANGE = 16 - GAP_SIZE - 2 * MIN_GAP_TOP + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPACE = 2'd1,
        PIPE  = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] pipe_q;
    logic        col_vld_q;
    logic        busy_q;
    logic [7:0]  score_q;
    logic [7:0]  lfsr_q;
    logic [7:0]  lfsr_d;
    logic [3:0]  space_cnt_q;
    logic [3:0]  gap_top_q;
    logic [3:0]  gap_top_d;
    logic [2:0]  pipe_cnt_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] gap_mask(input logic [3:0] top);
        logic [15:0] m;
        m = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            if (i >= int'(top) && i < int'(top) + GAP_SIZE) m[i] = 1'b0;
        end
        return m;
    endfunction

    // Right-shifting Fibonacci form of x^8+x^6+x^5+x^4+1.
    assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4], lfsr_q[7:1]};
    assign gap_top_d = 4'(MIN_GAP_TOP + (int'(lfsr_q[3:0]) % GAP_RANGE));

    always_ff @(posedge clkM or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pipe_q      <= 16'h0000;
            col_vld_q   <= 1'b0;
            busy_q      <= 1'b0;
            score_q     <= 8'd0;
            lfsr_q      <= LFSR_SEED;
            space_cnt_q <= 4'd0;
            pipe_cnt_q  <= 3'd0;
            gap_top_q   <= 4'd0;
        end else begin
            col_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q     <= SPACE;
                        busy_q      <= 1'b1;
                        score_q     <= 8'd0;
                        space_cnt_q <= 4'(PIPE_SPACING);
                    end
                end
                SPACE, PIPE: begin
                    // A collision cancels any column that would have issued this cycle.
                    if (bus.gameover) begin
                        state_q <= OVER;
                        busy_q  <= 1'b0;
                        pipe_q  <= 16'h0000;
                    end else if (bus.tick) begin
                        lfsr_q    <= lfsr_d;
                        col_vld_q <= 1'b1;
                        if (state_q == SPACE) begin
                            pipe_q      <= 16'h0000;
                            space_cnt_q <= space_cnt_q - 4'd1;
                            if (space_cnt_q == 4'd1) begin
                                state_q    <= PIPE;
                                pipe_cnt_q <= 3'(PIPE_WIDTH);
                                gap_top_q  <= gap_top_d;
                            end
                        end else begin
                            pipe_q     <= gap_mask(gap_top_q);
                            pipe_cnt_q <= pipe_cnt_q - 3'd1;
                            if (pipe_cnt_q == 3'd1) begin
                                state_q     <= SPACE;
                                space_cnt_q <= 4'(PIPE_SPACING);
                                score_q     <= sat_inc(score_q);
                            end
                        end
                    end
                end
                OVER: begin
                    if (bus.start && !bus.gameover) begin
                        state_q     <= SPACE;
                        busy_q      <= 1'b1;
                        score_q     <= 8'd0;
                        space_cnt_q <= 4'(PIPE_SPACING);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pipeRight = pipe_q;
    assign bus.colValid  = col_vld_q;
    assign bus.score     = score_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: directed vector table, hand-built corner sequences and
// random play checked every cycle against an obstacle-period reference model.
module tb_pipe_scheduler;
    localparam int SP  = 6;
    localparam int PW  = 2;
    localparam int GS  = 4;
    localparam int MG  = 1;
    localparam int RNG = 16 - GS - 2 * MG + 1;
    localparam int PERIOD = SP + PW;

    logic clkM;
    logic reset;
    pipe_scheduler_if bus ();

    pipe_scheduler #(
        .PIPE_WIDTH  (PW),
        .PIPE_SPACING(SP),
        .GAP_SIZE    (GS),
        .MIN_GAP_TOP (MG),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .clkM (clkM),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clkM = 1'b0;
        forever #5 clkM = ~clkM;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position within the repeating blank/pipe period.
    bit          m_playing;
    bit          m_started;
    int          m_pos;
    int          m_obst;
    logic [7:0]  m_lfsr;
    int          m_gap;
    logic [15:0] m_col;
    logic        m_vld;
    logic [7:0]  m_score;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {^(l & 8'h1D), l[7:1]};
    endfunction

    task automatic model_reset();
        m_playing = 0; m_started = 0; m_pos = 0; m_obst = 0;
        m_lfsr = 8'hA5; m_gap = 0; m_col = 16'h0; m_vld = 0; m_score = 0;
    endtask

    task automatic model_step(input logic s, input logic t, input logic g);
        m_vld = 0;
        if (m_playing) begin
            if (g) begin
                m_playing = 0;
                m_col = 16'h0;
            end else if (t) begin
                m_vld = 1;
                if (m_pos < SP) begin
                    m_col = 16'h0;
                    if (m_pos == SP - 1) m_gap = MG + (int'(m_lfsr[3:0]) % RNG);
                end else begin
                    m_col = 16'hFFFF ^ 16'(((1 << GS) - 1) << m_gap);
                    if (m_pos == PERIOD - 1) begin
                        m_obst++;
                        if (m_score != 8'd255) m_score = m_score + 8'd1;
                    end
                end
                m_lfsr = lfsr_next(m_lfsr);
                m_pos = (m_pos + 1) % PERIOD;
            end
        end else if (s && (!m_started || !g)) begin
            m_playing = 1; m_started = 1; m_pos = 0; m_score = 0;
        end
    endtask

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic [15:0] col, input logic vld,
                              input logic [7:0] sc, input logic bz);
        logic [31:0] act, req;
        act = {bus.pipeRight, bus.score, 6'd0, bus.colValid, bus.busy};
        req = {col, sc, 6'd0, vld, bz};
        check(name, act == req, act, req);
    endtask

    task automatic cyc(input logic s, input logic t, input logic g);
        @(negedge clkM);
        bus.start = s; bus.tick = t; bus.gameover = g;
        model_step(s, t, g);
        @(posedge clkM);
        #1;
        check_outs("model", m_col, m_vld, m_score, m_playing);
    endtask

    typedef struct {
        logic        s, t, g;
        logic [15:0] col;
        logic        vld;
        logic [7:0]  score;
        logic        busy;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic s, input logic t, input logic g, input logic [15:0] col,
                       input logic vld, input logic [7:0] sc, input logic bz);
        vec_t v;
        v.s = s; v.t = t; v.g = g; v.col = col; v.vld = vld; v.score = sc; v.busy = bz;
        tbl.push_back(v);
    endtask

    task automatic check_gap_shape();
        int z;
        logic [15:0] want;
        z = -1;
        for (int i = 15; i >= 0; i--) if (!bus.pipeRight[i]) z = i;
        want = (z < 0) ? 16'h0 : 16'hFFFF ^ 16'(16'h000F << z);
        check("gap_shape", z >= MG && z <= MG + RNG - 1 && bus.pipeRight == want,
              32'(bus.pipeRight), 32'(want));
    endtask

    initial begin
        int cycles;
        logic [7:0] sc_hold;

        // Directed table: start, six blank columns, two gap columns, back to blank.
        add(0, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 0, 0, 16'h0000, 0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            add(0, 1, 0, 16'h0000, 1, 0, 1);
            for (int j = 0; j < 3; j++) add(0, 0, 0, 16'h0000, 0, 0, 1);
        end
        add(0, 1, 0, 16'hFC3F, 1, 0, 1);
        for (int j = 0; j < 3; j++) add(0, 0, 0, 16'hFC3F, 0, 0, 1);
        add(1, 1, 0, 16'hFC3F, 1, 1, 1);
        for (int j = 0; j < 3; j++) add(0, 0, 0, 16'hFC3F, 0, 1, 1);
        add(0, 1, 0, 16'h0000, 1, 1, 1);

        bus.start = 0; bus.tick = 0; bus.gameover = 0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clkM);
        #1;
        check_outs("reset_state", 16'h0, 0, 0, 0);
        @(negedge clkM);
        reset = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].t, tbl[i].g);
            check_outs($sformatf("vec%0d", i), tbl[i].col, tbl[i].vld, tbl[i].score, tbl[i].busy);
        end

        // Long random play until score has saturated well past 255 obstacles.
        cycles = 0;
        while (m_obst < 300 && cycles < 30000) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            if (bus.colValid && bus.pipeRight != 16'h0) check_gap_shape();
            cycles++;
        end
        check("obstacles_reached", m_obst >= 300, 32'(m_obst), 32'd300);
        check("score_saturated", bus.score == 8'd255, 32'(bus.score), 32'd255);

        // Gameover coinciding with a tick while a pipe is being drawn.
        cycles = 0;
        while (!(m_playing && m_pos >= SP) && cycles < 100) begin
            cyc(0, 1, 0);
            cycles++;
        end
        sc_hold = bus.score;
        cyc(0, 1, 1);
        check_outs("gameover_tick", 16'h0, 0, sc_hold, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 0);
        check_outs("over_ticks", 16'h0, 0, sc_hold, 0);

        // Restart in OVER is blocked while gameover is still high.
        cyc(1, 0, 1);
        check_outs("over_start_blocked", 16'h0, 0, sc_hold, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        check_outs("over_restart", 16'h0, 0, 0, 1);
        cyc(0, 1, 0);
        check_outs("restart_blank", 16'h0, 1, 0, 1);

        // Random mix including collisions and restarts.
        for (int k = 0; k < 2000; k++) begin
            cyc(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 63) == 0));
            if (bus.colValid && bus.pipeRight != 16'h0) check_gap_shape();
        end

        // Asynchronous reset in the middle of a pipe.
        if (!m_playing) cyc(1, 0, 0);
        cycles = 0;
        while (!(m_playing && m_pos == SP + 1) && cycles < 100) begin
            cyc(0, 1, 0);
            cycles++;
        end
        check("in_pipe", bus.pipeRight != 16'h0 && bus.busy, 32'(bus.pipeRight), 32'hFFFF);
        @(negedge clkM);
        #2;
        bus.start = 0; bus.tick = 0; bus.gameover = 0;
        reset = 1'b0;
        #1;
        check_outs("async_reset", 16'h0, 0, 0, 0);
        model_reset();
        @(negedge clkM);
        reset = 1'b1;
        cyc(1, 0, 0);
        for (int k = 0; k < 6; k++) cyc(0, 1, 0);
        cyc(0, 1, 0);
        check_outs("reseed_gap", 16'hFC3F, 1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
